// File: rtl/mult_disp_pkg.sv
// Shared constants, state encoding and reset image for mult_disp_buffer.
// Optional hex display is built in when MULT_DISP_HEX_EN is defined.
package mult_disp_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_B     = 8'h42;
    localparam logic [7:0] CH_P     = 8'h50;
    localparam logic [7:0] CH_EQ    = 8'h3D;

    localparam int COL_A = 2;
    localparam int COL_B = 8;
    localparam int COL_P = 2;
    localparam int ROW1  = 16;

    localparam int CONV_CYCLES  = 16;
    localparam int WRITE_CYCLES = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef logic [31:0][7:0] image_t;

    function automatic image_t reset_image();
        image_t img;
        for (int i = 0; i < 32; i++) img[i] = CH_SPACE;
        img[0] = CH_A;
        img[1] = CH_EQ;
        img[6] = CH_B;
        img[7] = CH_EQ;
        img[ROW1]     = CH_P;
        img[ROW1 + 1] = CH_EQ;
        for (int i = 0; i < 3; i++) begin
            img[COL_A + i] = CH_ZERO;
            img[COL_B + i] = CH_ZERO;
        end
        for (int i = 0; i < 5; i++) img[ROW1 + COL_P + i] = CH_ZERO;
        return img;
    endfunction

    // Nibble to ASCII; decimal digits never exceed 9 so one mapping serves both modes
    function automatic logic [7:0] digit_char(logic [3:0] v);
        return (v < 4'd10) ? CH_ZERO + 8'(v) : 8'h37 + 8'(v);
    endfunction

endpackage

// File: rtl/mult_disp_if.sv
// Upstream/LCD-side signal bundle for mult_disp_buffer.
// hex_mode exists only when MULT_DISP_HEX_EN is defined.
interface mult_disp_if #(
    parameter int W_OP = 8,
    parameter int W_P  = 16
);
    logic            upd;
    logic [W_OP-1:0] a;
    logic [W_OP-1:0] b;
    logic [W_P-1:0]  p;
    logic            busy;
    logic            done;
    logic [4:0]      mem_addr;
    logic [7:0]      mem_bus;
`ifdef MULT_DISP_HEX_EN
    logic            hex_mode;

    modport master (
        output upd, a, b, p, mem_addr, hex_mode,
        input  busy, done, mem_bus
    );
    modport slave (
        input  upd, a, b, p, mem_addr, hex_mode,
        output busy, done, mem_bus
    );
`else
    modport master (
        output upd, a, b, p, mem_addr,
        input  busy, done, mem_bus
    );
    modport slave (
        input  upd, a, b, p, mem_addr,
        output busy, done, mem_bus
    );
`endif
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one bit per cycle, 16-bit binary to 5 BCD nibbles.
// no_add3 turns it into a plain shifter so nibbles become hex digits.
module bin2bcd_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        shift_en,
    input  logic        no_add3,
    input  logic [15:0] din,
    output logic [19:0] bcd
);
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [19:0] adj;
    logic [35:0] nxt;
    logic [35:0] nxt_ld;

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        adj = bcd_q;
        if (!no_add3) begin
            for (int i = 0; i < 5; i++) begin
                if (bcd_q[4*i +: 4] >= 4'd5)
                    adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        nxt    = {adj, bin_q} << 1;
        nxt_ld = {20'd0, din} << 1;
    end

    // start loads and performs the first shift in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= '0;
            bin_q <= '0;
        end else if (start) begin
            bcd_q <= nxt_ld[35:16];
            bin_q <= nxt_ld[15:0];
        end else if (shift_en) begin
            bcd_q <= nxt[35:16];
            bin_q <= nxt[15:0];
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/mult_disp_buffer.sv
// Operand/product formatter feeding the LCD driver's 32-byte screen image.
// Define MULT_DISP_HEX_EN to add the hex_mode display option.
module mult_disp_buffer
    import mult_disp_pkg::*;
#(
    parameter int W_OP = 8,
    parameter int W_P  = 16
) (
    input logic       clk,
    input logic       rst,
    mult_disp_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CONV  = CONV;
    localparam logic [1:0] ST_WRITE = WRITE;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [W_OP-1:0] a_q;
    logic [W_OP-1:0] b_q;
    logic [W_P-1:0]  p_q;
    logic            done_q;
    image_t          img;
    logic            hex_q;

    logic [19:0] bcd_a;
    logic [19:0] bcd_b;
    logic [19:0] bcd_p;
    logic        eng_start;
    logic        eng_shift;

    logic [4:0]  wr_addr;
    logic [19:0] wr_src;
    int          wr_idx;
    logic        wr_top;
    logic [3:0]  wr_val;
    logic [7:0]  wr_char;

    assign eng_start = (state == ST_CONV) && (cnt == 4'd0);
    assign eng_shift = (state == ST_CONV);

    bin2bcd_serial u_conv_a (
        .clk(clk), .rst(rst), .start(eng_start), .shift_en(eng_shift),
        .no_add3(hex_q), .din(16'(a_q)), .bcd(bcd_a)
    );

    bin2bcd_serial u_conv_b (
        .clk(clk), .rst(rst), .start(eng_start), .shift_en(eng_shift),
        .no_add3(hex_q), .din(16'(b_q)), .bcd(bcd_b)
    );

    bin2bcd_serial u_conv_p (
        .clk(clk), .rst(rst), .start(eng_start), .shift_en(eng_shift),
        .no_add3(hex_q), .din(16'(p_q)), .bcd(bcd_p)
    );

    // Map write step to screen address and source nibble, MS digit first
    always_comb begin
        wr_addr = '0;
        wr_src  = bcd_a;
        wr_idx  = 0;
        wr_top  = 1'b0;
        unique case (1'b1)
            (cnt <= 4'd2): begin
                wr_addr = 5'(COL_A) + 5'(cnt);
                wr_src  = bcd_a;
                wr_idx  = 2 - int'(cnt);
                wr_top  = (cnt == 4'd0);
            end
            (cnt >= 4'd3 && cnt <= 4'd5): begin
                wr_addr = 5'(COL_B) + 5'(cnt - 4'd3);
                wr_src  = bcd_b;
                wr_idx  = 5 - int'(cnt);
                wr_top  = (cnt == 4'd3);
            end
            (cnt >= 4'd6 && cnt <= 4'd10): begin
                wr_addr = 5'(ROW1 + COL_P) + 5'(cnt - 4'd6);
                wr_src  = bcd_p;
                wr_idx  = 10 - int'(cnt);
                wr_top  = (cnt == 4'd6);
            end
            default: ;
        endcase
        wr_val  = wr_src[4*wr_idx +: 4];
        wr_char = (wr_top && hex_q) ? CH_SPACE : digit_char(wr_val);
    end

`ifdef MULT_DISP_HEX_EN
    // Display mode is captured with the operands
    always_ff @(posedge clk) begin
        if (rst)
            hex_q <= 1'b0;
        else if (state == ST_IDLE && bus.upd)
            hex_q <= bus.hex_mode;
    end
`else
    assign hex_q = 1'b0;
`endif

    // Control FSM, operand latches and screen image
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
            img    <= reset_image();
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.upd) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        p_q   <= bus.p;
                        cnt   <= '0;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (cnt == 4'(CONV_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_WRITE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_WRITE: begin
                    img[wr_addr] <= wr_char;
                    if (cnt == 4'(WRITE_CYCLES - 1)) begin
                        cnt    <= '0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.mem_bus = img[bus.mem_addr];

endmodule

// File: tb/tb_mult_disp_buffer.sv
// Scoreboard bench for mult_disp_buffer: expected screen text is formatted
// from the operand values and checked by a monitor on every done pulse.
`timescale 1ns/10ps
module tb_mult_disp_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_disp_if #(.W_OP(8), .W_P(16)) bus ();

    mult_disp_buffer #(.W_OP(8), .W_P(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    dones  = 0;
    int    busy_cyc = 0;
    string exp_q[$];

    function automatic string exp_img(int a, int b, int p, bit hx);
        if (hx)
            return {$sformatf("A= %02X B= %02X     ", a, b),
                    $sformatf("P= %04X         ", p)};
        return {$sformatf("A=%03d B=%03d     ", a, b),
                $sformatf("P=%05d         ", p)};
    endfunction

    task automatic read_img(output string s);
        s = "";
        for (int i = 0; i < 32; i++) begin
            bus.mem_addr = 5'(i);
            #0.1;
            s = {s, $sformatf("%c", bus.mem_bus)};
        end
    endtask

    // Monitor: latency and image checked whenever done pulses
    initial begin
        string got;
        string exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cyc = 0;
            end else begin
                if (bus.busy) busy_cyc++;
                if (bus.done) begin
                    dones++;
                    checks++;
                    if (busy_cyc != 27) begin
                        errors++;
                        $display("FAIL latency got %0d want 27", busy_cyc);
                    end
                    busy_cyc = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done got done want none");
                    end else begin
                        exp = exp_q.pop_front();
                        read_img(got);
                        if (got != exp) begin
                            errors++;
                            $display("FAIL image got \"%s\" want \"%s\"",
                                     got, exp);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(int a, int b, int p, bit hx, bit push);
        @(negedge clk);
        bus.upd = 1'b1;
        bus.a   = 8'(a);
        bus.b   = 8'(b);
        bus.p   = 16'(p);
`ifdef MULT_DISP_HEX_EN
        bus.hex_mode = hx;
`endif
        if (push) exp_q.push_back(exp_img(a, b, p, hx));
        @(negedge clk);
        bus.upd = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL idle_timeout got busy=1 want busy=0");
        end
        @(negedge clk);
    endtask

    initial begin
        string got;
        int    d0;
        int    a;
        int    b;
        int    p;
        bit    hx;

        bus.upd      = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.p        = '0;
        bus.mem_addr = '0;
`ifdef MULT_DISP_HEX_EN
        bus.hex_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        read_img(got);
        checks++;
        if (got != exp_img(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_image got \"%s\"", got);
        end

        issue(13, 11, 143, 0, 1);
        wait_idle();
        issue(255, 255, 65025, 0, 1);
        wait_idle();
        issue(0, 0, 0, 0, 1);
        wait_idle();

        d0 = dones;
        issue(100, 200, 20000, 0, 1);
        repeat (3) @(negedge clk);
        bus.upd = 1'b1;
        bus.a   = 8'd7;
        bus.b   = 8'd7;
        bus.p   = 16'd49;
        @(negedge clk);
        bus.upd = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        checks++;
        if (dones - d0 != 1) begin
            errors++;
            $display("FAIL ignored_upd got %0d dones want 1", dones - d0);
        end

        d0 = dones;
        issue(99, 88, 8712, 0, 0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", bus.busy);
        end
        read_img(got);
        checks++;
        if (got != exp_img(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL abort_image got \"%s\"", got);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (dones != d0) begin
            errors++;
            $display("FAIL abort_done got %0d dones want 0", dones - d0);
        end

`ifdef MULT_DISP_HEX_EN
        issue(8'hAB, 8'h0F, 16'h0A05, 1, 1);
        wait_idle();
`endif

        for (int i = 0; i < 12; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            p  = (i % 2 == 0) ? a * b : int'($urandom_range(0, 65535));
            hx = 1'b0;
`ifdef MULT_DISP_HEX_EN
            hx = 1'($urandom_range(0, 1));
`endif
            issue(a, b, p, hx, 1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done got %0d pending want 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_disp_buffer.md
# mult_disp_buffer

Character buffer and formatter that sits directly upstream of the LCD driver. It latches the multiplier operands and product, converts them to ASCII with an iterative binary-to-BCD (double-dabble) engine, and writes the digits into a 32-byte, two-row screen image. The LCD driver reads that image through a 5-bit address / 8-bit data port.

## Interface
Parameters:
- `W_OP`, 8: operand width. Operands are shown as 3 decimal digits.
- `W_P`, 16: product width. The product is shown as 5 decimal digits.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `upd`, in, 1: single-cycle request to display new values. Sampled only in IDLE.
- `a`, in, `W_OP`: multiplicand.
- `b`, in, `W_OP`: multiplier.
- `p`, in, `W_P`: product.
- `busy`, out, 1: high while a conversion or write is in progress.
- `done`, out, 1: one-cycle pulse when the new image is complete.
- `mem_addr`, in, 5: {row, col} from the LCD driver.
- `mem_bus`, out, 8: ASCII character at `mem_addr`. Combinational read.
- `hex_mode`, in, 1: selects hex output. Present only with `MULT_DISP_HEX_EN`.

## Operation
- Screen image is 32 bytes. Address 0–15 is row 0, address 16–31 is row 1.
- Fixed characters, never rewritten after reset:
  - Row 0: `A` at col 0, `=` at col 1, space at col 5, `B` at col 6, `=` at col 7, spaces at cols 11–15.
  - Row 1: `P` at col 0, `=` at col 1, spaces at cols 7–15.
- Digit fields, most significant digit first:
  - A: row 0, cols 2–4.
  - B: row 0, cols 8–10.
  - P: row 1, cols 2–6.
- Decimal output keeps leading zeros.
- FSM states and transitions:
  - IDLE: on `upd`, latch `a`, `b`, `p` and go to CONV.
  - CONV: 16 cycles. Three parallel double-dabble engines each shift one bit per cycle; operands are zero-extended to 16 bits. Each engine adds 3 to any BCD nibble ≥5 before the shift. Then go to WRITE.
  - WRITE: 11 cycles, one digit per cycle in fixed order A2, A1, A0, B2, B1, B0, P4 … P0. Digit value v is written as 8'h30+v. Then go to IDLE and pulse `done`.
- `upd` while `busy` is high is ignored. No queuing.
- Mid-update reads may return a mix of old and new digits. The LCD driver tolerates this; no double buffering.
- Reset values:
  - `busy` = 0, `done` = 0, FSM in IDLE, latches cleared.
  - Image = row 0 "A=000 B=000" followed by 5 spaces; row 1 "P=00000" followed by 9 spaces.
  - Reset mid-CONV or mid-WRITE aborts the update and restores this image the next cycle. No `done` pulse.

## Timing
- `upd` sampled at edge 0. `busy` is high from edge 1 through edge 27, i.e. exactly 27 cycles (16 CONV + 11 WRITE).
- `done` is high for the one cycle in which `busy` returns low.
- The digit written at a WRITE edge is visible on `mem_bus` in the following cycle. The read path has no registers.
- Minimum spacing between accepted updates: 28 cycles.

## Configuration
- `MULT_DISP_HEX_EN` defined:
  - Adds the `hex_mode` input, sampled together with `upd`.
  - In hex mode, CONV still takes 16 cycles (shift only, no add-3), so timing is unchanged.
  - A and B: col 2 is a space, then 2 upper-case hex digits.
  - P: col 2 is a space, then 4 upper-case hex digits.
  - Hex digits 10–15 map to `A`–`F` (8'h41–8'h46).
- `MULT_DISP_HEX_EN` undefined: no `hex_mode` port; decimal only.

## Structure
- Package `mult_disp_pkg`:
  - ASCII constants: zero, space, `A`, `B`, `P`, `=`.
  - Field column constants.
  - FSM state enum {IDLE, CONV, WRITE}.
  - CONV and WRITE cycle counts.
  - Reset image function.
- Sub-module `bin2bcd_serial`: 16-bit in, 5 BCD nibbles out, with `start`, shift-enable, and add-3 bypass for hex. Instantiated three times (A, B, P).

## Test plan
- Reset, then read addresses 0–31 → "A=000 B=000     " and "P=00000         "; `busy` = 0.
- `upd` with a=13, b=11, p=143 → `busy` high for 27 cycles, `done` pulse, rows "A=013 B=011" and "P=00143".
- `upd` with a=255, b=255, p=65025 → "A=255 B=255", "P=65025". Then a=0, b=0, p=0 → all zeros.
- Second `upd` with a=7 at cycle 5 of a busy period → ignored; image shows the first values; exactly one `done`.
- `rst` at cycle 20 (in WRITE) → next cycle the image equals the reset image, `busy` = 0, no `done`.
- With `MULT_DISP_HEX_EN`: hex_mode=1, a=8'hAB, b=8'h0F, p=16'h0A05 → "A= AB B= 0F", "P= 0A05"; latency still 27 cycles.
